// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - shared types and defaults for the branch resolver
// Contents: PC_BITS_DEF (default PC width), br_state_t (RUN=0, SQUASH=1),
//           br_pred_t (prediction record {valid, pc, taken, target} at default width).
package br_pkg;

  localparam int PC_BITS_DEF = 12;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } br_state_t;

  typedef struct packed {
    logic                   valid;
    logic [PC_BITS_DEF-1:0] pc;
    logic                   taken;
    logic [PC_BITS_DEF-1:0] target;
  } br_pred_t;

endpackage

// File: rtl/br_pred_pipe.sv
// rtl/br_pred_pipe.sv - two-stage F->D->EX prediction register with stall/flush
// Ports: clk, rst (sync, active-high); stall holds both stages; flush clears both
//        valid bits and wins over stall; f_pc/f_taken/f_target is the fetch-stage
//        prediction; ex_valid/ex_pc/ex_taken/ex_target is the record now in EX.
module br_pred_pipe
  import br_pkg::*;
#(
  parameter int PC_BITS = PC_BITS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_BITS-1:0] f_pc,
  input  logic               f_taken,
  input  logic [PC_BITS-1:0] f_target,
  output logic               ex_valid,
  output logic [PC_BITS-1:0] ex_pc,
  output logic               ex_taken,
  output logic [PC_BITS-1:0] ex_target
);

  // Same field layout as br_pred_t, but sized by this instance's PC_BITS.
  typedef struct packed {
    logic               valid;
    logic [PC_BITS-1:0] pc;
    logic               taken;
    logic [PC_BITS-1:0] target;
  } pred_rec_t;

  pred_rec_t d_q;
  pred_rec_t ex_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q.valid  <= 1'b0;
      ex_q.valid <= 1'b0;
    end else if (flush) begin
      // Fetch and decode are squashed together, so nothing survives.
      d_q.valid  <= 1'b0;
      ex_q.valid <= 1'b0;
    end else if (!stall) begin
      d_q.valid  <= 1'b1;
      d_q.pc     <= f_pc;
      d_q.taken  <= f_taken;
      d_q.target <= f_target;
      ex_q       <= d_q;
    end
  end

  assign ex_valid  = ex_q.valid;
  assign ex_pc     = ex_q.pc;
  assign ex_taken  = ex_q.taken;
  assign ex_target = ex_q.target;

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - resolves EX branches against the carried prediction
// Ports: clk, rst (sync, active-high); F_pc/F_BP_taken/F_BP_target_pc fetch
//        prediction; F_stall/MEM_stall hold requests; EX_brn/EX_pc/EX_alu_out/
//        EX_true_taken resolved instruction; EX_flush/EX_redirect_pc squash and
//        restart; EX_upd_brn buffer update strobe; stat_branches/stat_mispred.
// Optional: BR_STATS_EN enables the saturating statistics counters; without it
//           both statistics outputs are tied to zero.
module branch_resolver #(
  parameter int PC_BITS  = br_pkg::PC_BITS_DEF,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_BITS-1:0]  F_pc,
  input  logic                F_BP_taken,
  input  logic [PC_BITS-1:0]  F_BP_target_pc,
  input  logic                F_stall,
  input  logic                MEM_stall,
  input  logic                EX_brn,
  input  logic [PC_BITS-1:0]  EX_pc,
  input  logic [PC_BITS-1:0]  EX_alu_out,
  input  logic                EX_true_taken,
  output logic                EX_flush,
  output logic [PC_BITS-1:0]  EX_redirect_pc,
  output logic                EX_upd_brn,
  output logic [CNT_BITS-1:0] stat_branches,
  output logic [CNT_BITS-1:0] stat_mispred
);

  import br_pkg::*;

  localparam logic [PC_BITS-1:0] PC_ONE = {{(PC_BITS-1){1'b0}}, 1'b1};

  br_state_t          state;
  logic               ex_valid;
  logic [PC_BITS-1:0] ex_pred_pc;
  logic               ex_taken;
  logic [PC_BITS-1:0] ex_target;
  logic               eff_taken;
  logic               mispredict;
  logic               active;
  logic [PC_BITS-1:0] seq_pc;

  br_pred_pipe #(
    .PC_BITS (PC_BITS)
  ) u_pred_pipe (
    .clk       (clk),
    .rst       (rst),
    .stall     (F_stall | MEM_stall),
    .flush     (EX_flush),
    .f_pc      (F_pc),
    .f_taken   (F_BP_taken),
    .f_target  (F_BP_target_pc),
    .ex_valid  (ex_valid),
    .ex_pc     (ex_pred_pc),
    .ex_taken  (ex_taken),
    .ex_target (ex_target)
  );

  // A prediction only counts when it was made for the instruction now in EX.
  always_comb begin
    eff_taken = ex_valid && (ex_pred_pc == EX_pc) && ex_taken;
    if (EX_brn) begin
      mispredict = (eff_taken != EX_true_taken) ||
                   (eff_taken && EX_true_taken && (ex_target != EX_alu_out));
    end else begin
      mispredict = eff_taken;
    end
  end

  // EX inputs are held while MEM_stall is high, so a pending mispredict simply
  // re-evaluates and fires on the first unstalled cycle; SQUASH then blocks a
  // second flag for the same instruction.
  assign active         = !rst && !MEM_stall && (state == RUN);
  assign EX_flush       = mispredict && active;
  assign EX_upd_brn     = EX_brn && active;
  assign seq_pc         = EX_pc + PC_ONE;
  assign EX_redirect_pc = !EX_flush                 ? '0 :
                          (EX_brn && EX_true_taken) ? EX_alu_out : seq_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (EX_flush)   state <= SQUASH;
        SQUASH:  if (!MEM_stall) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef BR_STATS_EN
  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  logic [CNT_BITS-1:0] branches_q;
  logic [CNT_BITS-1:0] mispred_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      branches_q <= '0;
      mispred_q  <= '0;
    end else begin
      if (EX_upd_brn && (branches_q != '1)) branches_q <= branches_q + CNT_ONE;
      if (EX_flush && (mispred_q != '1))    mispred_q  <= mispred_q + CNT_ONE;
    end
  end

  assign stat_branches = branches_q;
  assign stat_mispred  = mispred_q;
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - self-checking bench for branch_resolver
module tb_branch_resolver;
  import br_pkg::*;

  localparam int PCW     = PC_BITS_DEF;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef BR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [PCW-1:0]   F_pc, F_BP_target_pc, EX_pc, EX_alu_out;
  logic             F_BP_taken, F_stall, MEM_stall, EX_brn, EX_true_taken;
  logic             EX_flush, EX_upd_brn;
  logic [PCW-1:0]   EX_redirect_pc;
  logic [CNT_W-1:0] stat_branches, stat_mispred;

  branch_resolver #(.PC_BITS(PCW), .CNT_BITS(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .F_pc(F_pc), .F_BP_taken(F_BP_taken), .F_BP_target_pc(F_BP_target_pc),
    .F_stall(F_stall), .MEM_stall(MEM_stall),
    .EX_brn(EX_brn), .EX_pc(EX_pc), .EX_alu_out(EX_alu_out), .EX_true_taken(EX_true_taken),
    .EX_flush(EX_flush), .EX_redirect_pc(EX_redirect_pc), .EX_upd_brn(EX_upd_brn),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the prediction record sitting in D and in EX, whether the
  // cycle after a flush is the bubble cycle, and the two statistics counts.
  br_pred_t m_d      = '0;
  br_pred_t m_ex     = '0;
  bit       m_squash = 1'b0;
  int       m_br     = 0;
  int       m_mis    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_out(output logic f, output logic [PCW-1:0] r, output logic u);
    logic hit_taken, wrong, live;
    hit_taken = m_ex.valid && (m_ex.pc == EX_pc) && m_ex.taken;
    if (EX_brn) wrong = (hit_taken != EX_true_taken) ||
                        (hit_taken && EX_true_taken && (m_ex.target != EX_alu_out));
    else        wrong = hit_taken;
    live = !rst && !MEM_stall && !m_squash;
    f = wrong && live;
    u = EX_brn && live;
    if (!f)                        r = '0;
    else if (EX_brn && EX_true_taken) r = EX_alu_out;
    else                           r = PCW'((int'(EX_pc) + 1) % (1 << PCW));
  endfunction

  always @(posedge clk) begin
    logic f, u;
    logic [PCW-1:0] r;
    model_out(f, r, u);
    if (rst) begin
      m_d.valid = 1'b0; m_ex.valid = 1'b0; m_squash = 1'b0; m_br = 0; m_mis = 0;
    end else begin
      if (f) begin
        m_d.valid = 1'b0; m_ex.valid = 1'b0;
      end else if (!(F_stall || MEM_stall)) begin
        m_ex = m_d;
        m_d  = '{valid: 1'b1, pc: F_pc, taken: F_BP_taken, target: F_BP_target_pc};
      end
      m_squash = m_squash ? MEM_stall : f;
      if (STATS) begin
        if (u && m_br  < CNT_MAX) m_br++;
        if (f && m_mis < CNT_MAX) m_mis++;
      end
    end
  end

  always @(negedge clk) begin
    logic f, u;
    logic [PCW-1:0] r;
    model_out(f, r, u);
    chk("mdl_flush",    32'(EX_flush),       32'(f));
    chk("mdl_redirect", 32'(EX_redirect_pc), 32'(r));
    chk("mdl_upd",      32'(EX_upd_brn),     32'(u));
    chk("mdl_stat_br",  32'(stat_branches),  32'(m_br));
    chk("mdl_stat_mis", 32'(stat_mispred),   32'(m_mis));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    F_pc = 12'h300; F_BP_taken = 1'b0; F_BP_target_pc = '0;
    F_stall = 1'b0; MEM_stall = 1'b0;
    EX_brn = 1'b0; EX_pc = 12'h7FF; EX_alu_out = '0; EX_true_taken = 1'b0;
  endtask

  task automatic ex_drive(input logic brn, input logic [PCW-1:0] pc,
                          input logic tk, input logic [PCW-1:0] alu);
    EX_brn = brn; EX_pc = pc; EX_true_taken = tk; EX_alu_out = alu;
  endtask

  task automatic load_pred(input logic [PCW-1:0] pc, input logic tk, input logic [PCW-1:0] tgt);
    F_pc = pc; F_BP_taken = tk; F_BP_target_pc = tgt;
    tick();
    idle();
    tick();
  endtask

  task automatic chk_out(input string name, input logic f, input logic [PCW-1:0] r, input logic u);
    @(negedge clk);
    chk({name, "_flush"},    32'(EX_flush),       32'(f));
    chk({name, "_redirect"}, 32'(EX_redirect_pc), 32'(r));
    chk({name, "_upd"},      32'(EX_upd_brn),     32'(u));
  endtask

  task automatic chk_stats(input string name, input int br, input int mis);
    @(negedge clk);
    chk({name, "_branches"}, 32'(stat_branches), STATS ? 32'(br)  : 32'd0);
    chk({name, "_mispred"},  32'(stat_mispred),  STATS ? 32'(mis) : 32'd0);
  endtask

  initial begin
    int exp_br, exp_mis;
    rst = 1'b1;
    idle();
    // Reset must hold both strobes low even with a mispredicting branch in EX.
    ex_drive(1'b1, 12'h7FE, 1'b1, 12'h100);
    chk_out("rst0", 1'b0, 12'h000, 1'b0);
    tick();
    chk_out("rst1", 1'b0, 12'h000, 1'b0);
    tick();
    rst = 1'b0;
    idle();
    chk_stats("after_rst", 0, 0);
    tick();

    // Correct taken prediction.
    load_pred(12'h010, 1'b1, 12'h040);
    ex_drive(1'b1, 12'h010, 1'b1, 12'h040);
    chk_out("correct_taken", 1'b0, 12'h000, 1'b1);
    tick();
    idle();
    exp_br = 1; exp_mis = 0;
    chk_stats("correct_taken", exp_br, exp_mis);
    tick();

    // Direction mispredict, then the bubble cycle ignores EX_brn.
    load_pred(12'h020, 1'b0, 12'h000);
    ex_drive(1'b1, 12'h020, 1'b1, 12'h080);
    chk_out("dir_mispred", 1'b1, 12'h080, 1'b1);
    tick();
    chk_out("squash_cycle", 1'b0, 12'h000, 1'b0);
    exp_br = 2; exp_mis = 1;
    chk_stats("dir_mispred", exp_br, exp_mis);
    tick();
    idle();
    tick();

    // Target mispredict.
    load_pred(12'h030, 1'b1, 12'h050);
    ex_drive(1'b1, 12'h030, 1'b1, 12'h060);
    chk_out("tgt_mispred", 1'b1, 12'h060, 1'b1);
    tick();
    idle();
    exp_br = 3; exp_mis = 2;
    chk_stats("tgt_mispred", exp_br, exp_mis);
    tick();

    // Aliased non-branch predicted taken at the top of the PC space.
    load_pred(12'hFFF, 1'b1, 12'h123);
    ex_drive(1'b0, 12'hFFF, 1'b0, 12'h000);
    chk_out("alias_wrap", 1'b1, 12'h000, 1'b0);
    tick();
    idle();
    exp_mis = 3;
    chk_stats("alias_wrap", exp_br, exp_mis);
    tick();

    // Mispredict held off by MEM_stall for three cycles.
    load_pred(12'h040, 1'b0, 12'h000);
    ex_drive(1'b1, 12'h040, 1'b1, 12'h0AA);
    MEM_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_out("stall_hold", 1'b0, 12'h000, 1'b0);
      tick();
    end
    MEM_stall = 1'b0;
    chk_out("stall_release", 1'b1, 12'h0AA, 1'b1);
    tick();
    chk_out("stall_once", 1'b0, 12'h000, 1'b0);
    exp_br = 4; exp_mis = 4;
    chk_stats("stall_mispred", exp_br, exp_mis);
    tick();
    idle();
    tick();

    // Reset during SQUASH.
    ex_drive(1'b1, 12'h7FE, 1'b1, 12'h100);
    chk_out("pre_rst_flush", 1'b1, 12'h100, 1'b1);
    tick();
    rst = 1'b1;
    F_pc = 12'h066; F_BP_taken = 1'b1; F_BP_target_pc = 12'h099;
    chk_out("rst_in_squash", 1'b0, 12'h000, 1'b0);
    tick();
    rst = 1'b0;
    idle();
    ex_drive(1'b1, 12'h010, 1'b0, 12'h000);
    chk_out("post_rst_branch", 1'b0, 12'h000, 1'b1);
    chk_stats("post_rst", 0, 0);
    tick();
    idle();
    exp_br = 1; exp_mis = 0;
    chk_stats("post_rst_count", exp_br, exp_mis);
    tick();

    // Drive the mispredict counter past its all-ones value.
    for (int i = 0; i < CNT_MAX + 1; i++) begin
      ex_drive(1'b1, 12'h7FE, 1'b1, 12'h100);
      tick();
      idle();
      tick();
    end
    chk_stats("saturate", CNT_MAX, CNT_MAX);

    // Randomised traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 63) == 0);
      F_stall        = ($urandom_range(0, 5) == 0);
      MEM_stall      = ($urandom_range(0, 5) == 0);
      F_pc           = ($urandom_range(0, 15) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      F_BP_taken     = 1'($urandom_range(0, 1));
      F_BP_target_pc = 12'($urandom_range(0, 15));
      EX_brn         = 1'($urandom_range(0, 1));
      EX_true_taken  = 1'($urandom_range(0, 1));
      EX_pc          = ($urandom_range(0, 9) < 6) ? m_ex.pc : 12'($urandom_range(0, 15));
      EX_alu_out     = ($urandom_range(0, 1) == 1) ? m_ex.target : 12'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter PC_BITS, default 12, meaning width of every PC and target field.
REQ-002 SHALL have parameter CNT_BITS, default 16, meaning width of each statistics counter.
REQ-003 SHALL have ports clk (input, 1, sole clock) and rst (input, 1, reset; synchronous, active-high).
REQ-004 SHALL have F_pc (input, PC_BITS), F_BP_taken (input, 1) and F_BP_target_pc (input, PC_BITS): the fetch-stage PC and the branch buffer's prediction for it.
REQ-005 SHALL have F_stall (input, 1) and MEM_stall (input, 1): pipeline hold requests.
REQ-006 SHALL have EX_brn (input, 1), EX_pc (input, PC_BITS), EX_alu_out (input, PC_BITS) and EX_true_taken (input, 1): the resolved execute-stage instruction.
REQ-007 SHALL have EX_flush (output, 1): squash the F and D stages this cycle.
REQ-008 SHALL have EX_redirect_pc (output, PC_BITS): the correct next PC, valid while EX_flush is high.
REQ-009 SHALL have EX_upd_brn (output, 1): branch-buffer update strobe, driving that block's EX_brn input.
REQ-010 SHALL have stat_branches (output, CNT_BITS) and stat_mispred (output, CNT_BITS): statistics counters.

Function
REQ-011 SHALL carry {valid, pc, pred_taken, pred_target} from F to D to EX in two registers; stall = F_stall | MEM_stall; both registers hold when stall=1.
REQ-012 SHALL clear the valid bit of both D and EX prediction registers in any cycle in which EX_flush=1; the flush takes priority over stall.
REQ-013 SHALL use the EX prediction (eff_taken) only when EX valid=1 and its pc == EX_pc; otherwise eff_taken=0.
REQ-014 SHALL declare a mispredict, when EX_brn=1, if eff_taken != EX_true_taken, or if both are 1 and pred_target != EX_alu_out.
REQ-015 SHALL declare a mispredict when EX_brn=0 and eff_taken=1 (aliased prediction on a non-branch).
REQ-016 SHALL set EX_redirect_pc = EX_alu_out when EX_brn & EX_true_taken, else EX_pc+1, wrapping modulo 2^PC_BITS.
REQ-017 SHALL drive EX_flush combinationally, in the same cycle: mispredict & !MEM_stall & state==RUN.
REQ-018 SHALL drive EX_upd_brn = EX_brn & !MEM_stall & state==RUN, so each branch updates the buffer exactly once.
REQ-019 SHALL have FSM states RUN and SQUASH; RUN->SQUASH on EX_flush; SQUASH->RUN unconditionally after one cycle, unless MEM_stall=1, which holds SQUASH.
REQ-020 SHALL, in SQUASH, force EX_flush=0 and EX_upd_brn=0 regardless of EX inputs, because EX holds a bubble.
REQ-021 SHALL defer a mispredict pending under MEM_stall and flag it, exactly once, in the first cycle with MEM_stall=0.
REQ-022 SHALL drive EX_redirect_pc = 0 while EX_flush=0.

Reset
REQ-023 SHALL, on rst=1 at a clk edge: clear all prediction valid bits, set state RUN, and zero both counters.
REQ-024 SHALL hold EX_flush and EX_upd_brn at 0 during reset.
REQ-025 SHALL abandon SQUASH and return to RUN on a reset asserted mid-operation, with no flush emitted in the following cycle.

Configuration
REQ-026 SHALL, with BR_STATS_EN defined, increment stat_branches on each EX_upd_brn=1 and stat_mispred on each EX_flush=1, both saturating at all-ones.
REQ-027 SHALL, without BR_STATS_EN, tie stat_branches and stat_mispred to 0 and synthesize no counter registers.

Structure
REQ-028 SHALL place in shared package br_pkg: the PC_BITS default, the FSM state encoding (RUN=0, SQUASH=1) and the prediction-record typedef {valid, pc, taken, target}.
REQ-029 SHALL instantiate one sub-module, br_pred_pipe, holding the two-stage prediction register with stall/flush controls; compare logic, FSM and counters stay in branch_resolver.

Verification
REQ-030 SHALL cover correct taken prediction: pred taken target 0x040 at pc 0x010, EX_brn=1, true_taken=1, alu_out=0x040 -> EX_flush=0, EX_upd_brn=1, stat_branches +1.
REQ-031 SHALL cover direction mispredict: pred not-taken at pc 0x020, EX true_taken=1, alu_out=0x080 -> EX_flush=1, redirect 0x080, next cycle SQUASH with EX_flush=0 despite EX_brn=1.
REQ-032 SHALL cover target mispredict: pred taken to 0x050, alu_out=0x060 -> EX_flush=1, redirect 0x060; aliased non-branch predicted taken at pc 0xFFF -> EX_flush=1, redirect 0x000.
REQ-033 SHALL cover mispredict while MEM_stall=1 for 3 cycles -> EX_flush=0 for those 3 cycles, then 1 for exactly one cycle, stat_mispred +1.
REQ-034 SHALL cover rst asserted during SQUASH -> state RUN, counters 0, valid bits 0, and a subsequent correct branch yields no flush.
REQ-035 SHALL cover BR_STATS_EN with stat_mispred at 0xFFFF plus one further mispredict -> counter stays 0xFFFF.
